seg7_multidigit_scan_driver: RTL and testbench
==============================================

// Module: seg7_multidigit_scan_driver
// PURPOSE
//   Parametrised N-digit 7-segment display driver; successor to the fixed dual-digit decoder.
//   Latches a packed BCD/hex word on load and decodes each nibble with optional hex glyphs,
//   leading-zero blanking, per-digit blink and decimal points.
//   Drives both per-digit static segment buses and a time-multiplexed scan bus (seg + anodes).
//   Sits between datapath counters/results and board display pins.
// PARAMETERS
//   NUM_DIGITS     4         digits handled (>=1)
//   SCAN_DIV       50000     clk cycles each digit is shown in scan mode (>=2)
//   BLINK_DIV      25000000  clk cycles per blink phase toggle (>=1)
//   ACTIVE_LOW_AN  1         1: anode enables active-low; 0: active-high
// PORTS
//   clk          in   1              system clock, all logic on rising edge
//   reset        in   1              synchronous, active-high
//   load         in   1              capture digits_in/dp_in into shadow registers
//   digits_in    in   4*NUM_DIGITS   nibble k = digit k; digit 0 least significant
//   dp_in        in   NUM_DIGITS     decimal point per digit, 1 = lit
//   hex_mode     in   1              1: nibbles 10-15 show A,b,C,d,E,F; 0: shown blank
//   blank_lz     in   1              1: suppress leading zeros
//   blink_mask   in   NUM_DIGITS     1 = digit blanks during blink-off phase
//   seg_par      out  7*NUM_DIGITS   static segments, group k = digit k, bit0=a..bit6=g, active-low
//   seg_scan     out  7              scanned segments of current digit, active-low
//   dp_scan      out  1              scanned decimal point, active-low
//   an           out  NUM_DIGITS     one-hot digit enable, polarity per ACTIVE_LOW_AN
// BEHAVIOUR
//   Reset: shadow digits/dp = 0; seg_par all 7'b1111111; seg_scan 7'b1111111; dp_scan 1;
//     an all inactive; scan index 0; scan/blink counters 0; blink phase = on (0). reset beats load.
//   Shadow: load sampled at edge N -> shadow valid after edge N; load held high re-captures each cycle.
//   Decode (active-low, a=bit0): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010
//     6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001
//     E=0000110 F=0001110; 10-15 with hex_mode=0 -> 1111111.
//   hex_mode, blank_lz, blink_mask are live (not latched); effect visible one edge after change.
//   Leading-zero blank: digits from NUM_DIGITS-1 down to first nonzero nibble that equal 0 are
//     blanked (segments and dp off); digit 0 never blanked; nibble 10-15 counts as nonzero.
//   Blink: counter wraps at BLINK_DIV-1 and toggles phase; phase=1 blanks digits with mask bit set.
//   seg_par latency: 1 edge from shadow/live-input change (2 edges from load assertion).
//   Scan: counter 0..SCAN_DIV-1; at SCAN_DIV-1 index advances, NUM_DIGITS-1 wraps to 0.
//   Ghost guard: on the cycle the index changes, an all inactive for exactly 1 cycle, seg_scan
//     1111111; next cycle an enables new digit with its registered segments and dp.
//   First an enable: digit 0, on the edge 1 cycle after reset deasserts, held SCAN_DIV-1 cycles.
//   Scan bus shows same decoded/blanked/blinked value as seg_par group for the current index.
//   NUM_DIGITS=1: index stays 0; ghost guard still applied every SCAN_DIV cycles.
//   Reset mid-scan: all state returns to reset values on that edge; no partial digit output.
// TESTING
//   Reset 3 cycles -> seg_par all 1s, an=4'b1111, seg_scan=1111111, dp_scan=1.
//   load 16'h0907, blank_lz=1, hex=0 -> 2 edges later seg_par = {1111111,0010000,1000000,1111000}.
//   load 16'hABCD hex=1 -> groups 3..0 = 0001000,0000011,1000110,0100001; hex=0 -> all four 1111111.
//   load 16'h0000 blank_lz=1 -> digits 3..1 blank, digit 0 = 1000000; blank_lz=0 -> all 1000000.
//   SCAN_DIV=4: an sequence 1110 x3, 1111 x1, 1101 x3, 1111, 1011..., 0111 then wraps to 1110.
//   BLINK_DIV=8, blink_mask=4'b0010 -> digit 1 blank for 8 cycles, shown 8; reset mid-blink -> shown.

Source files
------------

// File: rtl/seg7_multidigit_scan_driver.sv
// seg7_multidigit_scan_driver: N-digit 7-segment decoder with static and time-multiplexed outputs
module seg7_multidigit_scan_driver #(
  parameter int NUM_DIGITS    = 4,
  parameter int SCAN_DIV      = 50000,
  parameter int BLINK_DIV     = 25000000,
  parameter int ACTIVE_LOW_AN = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    hex_mode,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7*NUM_DIGITS-1:0] seg_par,
  output logic [6:0]              seg_scan,
  output logic                    dp_scan,
  output logic [NUM_DIGITS-1:0]   an
);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic AL = ACTIVE_LOW_AN != 0;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'ha: glyph = 7'b0001000;
      4'hb: glyph = 7'b0000011;
      4'hc: glyph = 7'b1000110;
      4'hd: glyph = 7'b0100001;
      4'he: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d, active;
  logic [SW-1:0]           scan_cnt, scan_cnt_nxt;
  logic [BW-1:0]           blink_cnt;
  logic [IW-1:0]           idx, idx_nxt;
  logic                    phase, scan_wrap, blink_wrap, lz, off;
  logic [3:0]              nib;
  logic [6:0]              seg_d [NUM_DIGITS];

  // lz stays set while every nibble from the top down to k is zero
  always_comb begin
    lz = 1'b1;
    nib = '0;
    off = 1'b0;
    dp_d = '1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nib = digits_q[4*k +: 4];
      lz = lz && nib == 4'd0;
      off = (blank_lz && lz && k != 0) || (phase && blink_mask[k]);
      seg_d[k] = off || (nib > 4'd9 && !hex_mode) ? 7'h7f : glyph(nib);
      dp_d[k] = off || !dp_q[k];
    end
  end

  always_comb begin
    scan_wrap = scan_cnt == SW'(SCAN_DIV - 1);
    blink_wrap = blink_cnt == BW'(BLINK_DIV - 1);
    scan_cnt_nxt = scan_wrap ? '0 : scan_cnt + 1'b1;
    idx_nxt = !scan_wrap ? idx : idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
    active = scan_wrap ? '0 : NUM_DIGITS'(1) << idx_nxt;
  end

  // scan outputs register the upcoming index so the blank guard cycle lines up with the index change
  always_ff @(posedge clk) begin
    if (reset) begin
      digits_q  <= '0;
      dp_q      <= '0;
      scan_cnt  <= '0;
      blink_cnt <= '0;
      idx       <= '0;
      phase     <= 1'b0;
      seg_par   <= '1;
      seg_scan  <= '1;
      dp_scan   <= 1'b1;
      an        <= {NUM_DIGITS{AL}};
    end else begin
      if (load) begin
        digits_q <= digits_in;
        dp_q     <= dp_in;
      end
      scan_cnt  <= scan_cnt_nxt;
      idx       <= idx_nxt;
      blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
      phase     <= phase ^ blink_wrap;
      for (int k = 0; k < NUM_DIGITS; k++) seg_par[7*k +: 7] <= seg_d[k];
      seg_scan  <= scan_wrap ? 7'h7f : seg_d[idx_nxt];
      dp_scan   <= scan_wrap || dp_d[idx_nxt];
      an        <= active ^ {NUM_DIGITS{AL}};
    end
  end
endmodule

// File: tb/tb_seg7_multidigit_scan_driver.sv
// tb_seg7_multidigit_scan_driver: scoreboard bench with a cycle-count reference model
module tb_seg7_multidigit_scan_driver;
  localparam int ND = 4, SCN = 4, BLK = 8;

  logic clk = 0, reset = 1, load = 0, hex_mode = 0, blank_lz = 0;
  logic [4*ND-1:0] digits_in = '0;
  logic [ND-1:0] dp_in = '0, blink_mask = '0, an;
  logic [7*ND-1:0] seg_par;
  logic [6:0] seg_scan;
  logic dp_scan;
  int total = 0, bad = 0;

  seg7_multidigit_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SCN), .BLINK_DIV(BLK), .ACTIVE_LOW_AN(1)) dut (
    .clk(clk), .reset(reset), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .hex_mode(hex_mode), .blank_lz(blank_lz), .blink_mask(blink_mask),
    .seg_par(seg_par), .seg_scan(seg_scan), .dp_scan(dp_scan), .an(an));

  always #5 clk = ~clk;

  typedef struct {logic [7*ND-1:0] sp; logic [6:0] ss; logic dps; logic [ND-1:0] an;} exp_t;
  exp_t q[$];
  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad < 40) $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: outputs after edge e follow from e alone (scan slot, blink half-period)
  int e = 0;
  logic [4*ND-1:0] sh = '0;
  logic [ND-1:0] shdp = '0;
  always @(posedge clk) begin
    exp_t x;
    logic [ND-1:0] off;
    int d, ph;
    if (reset) begin
      e = 0; sh = '0; shdp = '0;
      x.sp = '1; x.ss = 7'h7f; x.dps = 1'b1; x.an = '1;
    end else begin
      e++;
      ph = ((e - 1) / BLK) % 2;
      for (int k = 0; k < ND; k++) begin
        off[k] = (blank_lz && k > 0 && (sh >> (4*k)) == 0) || (ph == 1 && blink_mask[k]);
        x.sp[7*k +: 7] = off[k] || (sh[4*k +: 4] > 9 && !hex_mode) ? 7'h7f : tbl[sh[4*k +: 4]];
      end
      if (e % SCN == 0) begin
        x.ss = 7'h7f; x.dps = 1'b1; x.an = '1;
      end else begin
        d = (e / SCN) % ND;
        x.ss = x.sp[7*d +: 7];
        x.dps = off[d] | ~shdp[d];
        x.an = ~(ND'(1) << d);
      end
      if (load) begin sh = digits_in; shdp = dp_in; end
    end
    q.push_back(x);
  end

  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("sb_seg_par", 32'(seg_par), 32'(x.sp));
      chk("sb_seg_scan", 32'(seg_scan), 32'(x.ss));
      chk("sb_dp_scan", 32'(dp_scan), 32'(x.dps));
      chk("sb_an", 32'(an), 32'(x.an));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [15:0] w);
    load = 1; digits_in = w; step(1);
    load = 0; step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [ND-1:0] an_pat [17] = '{4'he, 4'he, 4'he, 4'hf, 4'hd, 4'hd, 4'hd, 4'hf,
                                   4'hb, 4'hb, 4'hb, 4'hf, 4'h7, 4'h7, 4'h7, 4'hf, 4'he};
    int offs, n;
    step(3);
    chk("rst_seg_par", 32'(seg_par), 32'h0fff_ffff);
    chk("rst_an", 32'(an), 32'hf);
    chk("rst_seg_scan", 32'(seg_scan), 32'h7f);
    chk("rst_dp_scan", 32'(dp_scan), 32'h1);
    reset = 0; blank_lz = 1;
    load_word(16'h0907);
    chk("lz_0907", 32'(seg_par), 32'({7'h7f, 7'h10, 7'h40, 7'h78}));
    hex_mode = 1;
    load_word(16'hABCD);
    chk("hex_abcd", 32'(seg_par), 32'({7'h08, 7'h03, 7'h46, 7'h21}));
    hex_mode = 0; step(1);
    chk("nohex_abcd", 32'(seg_par), 32'h0fff_ffff);
    load_word(16'h0000);
    chk("lz_zero", 32'(seg_par), 32'({7'h7f, 7'h7f, 7'h7f, 7'h40}));
    blank_lz = 0; step(1);
    chk("nolz_zero", 32'(seg_par), 32'({7'h40, 7'h40, 7'h40, 7'h40}));
    reset = 1; step(1); reset = 0;
    for (int i = 0; i < 17; i++) begin
      step(1);
      chk("scan_an", 32'(an), 32'(an_pat[i]));
    end
    reset = 1; step(1); reset = 0;
    blink_mask = 4'b0010;
    load_word(16'h1111);
    offs = 0;
    for (int i = 0; i < 16; i++) begin
      offs += seg_par[13:7] == 7'h7f ? 1 : 0;
      step(1);
    end
    chk("blink_off_count", 32'(offs), 32'd8);
    n = 0;
    while (seg_par[13:7] != 7'h7f && n < 20) begin step(1); n++; end
    chk("blink_reached_off", 32'(seg_par[13:7]), 32'h7f);
    reset = 1; step(1);
    chk("blink_rst", 32'(seg_par), 32'h0fff_ffff);
    reset = 0; step(1);
    chk("blink_after_rst", 32'(seg_par[13:7]), 32'h40);
    for (int i = 0; i < 800; i++) begin
      reset = $urandom_range(99) == 0;
      load = $urandom_range(3) == 0;
      for (int k = 0; k < ND; k++) digits_in[4*k +: 4] = $urandom_range(1) ? 4'd0 : 4'($urandom_range(15));
      dp_in = ND'($urandom);
      if ($urandom_range(7) == 0) begin
        hex_mode = 1'($urandom);
        blank_lz = 1'($urandom);
        blink_mask = ND'($urandom);
      end
      step(1);
    end
    reset = 0; load = 0;
    step(2);
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
